px_stream_router: RTL and testbench

PX_STREAM_ROUTER -- requirements
Module: px_stream_router

---
 rtl/px_stream_router.sv | 134 +++++++++++++
 tb/tb_px_stream_router.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/px_stream_router.sv
// px_stream_router: forwards pixels from one selected source to a processing core and
// buffers the core's results in a show-ahead FIFO, framed by a latched pixel count.
module px_stream_router #(
    parameter int PX_W  = 24,
    parameter int N_SRC = 2,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16,
    localparam int SEL_W = (N_SRC > 1) ? $clog2(N_SRC) : 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  nreset_i,
    input  logic                  start_i,
    input  logic                  clr_i,
    input  logic [SEL_W-1:0]      sel_i,
    input  logic [CNT_W-1:0]      frame_len_i,
    input  logic [N_SRC*PX_W-1:0] src_px_i,
    input  logic [N_SRC-1:0]      src_rdy_i,
    output logic [PX_W-1:0]       core_px_o,
    output logic                  core_rdy_o,
    input  logic [PX_W-1:0]       core_px_i,
    input  logic                  core_rdy_i,
    output logic [PX_W-1:0]       sink_px_o,
    output logic                  sink_vld_o,
    input  logic                  sink_ack_i,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  ovf_o
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t           state;
    logic [SEL_W-1:0] sel;
    logic [CNT_W-1:0] len;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [PX_W-1:0]  mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [PX_W-1:0]  sel_px;
    logic             sel_rdy;
    logic             push;
    logic             pop;
    logic             full;
    logic             wr_en;

    always_comb begin
        sel_px  = '0;
        sel_rdy = 1'b0;
        for (int k = 0; k < N_SRC; k++) begin
            if (sel == SEL_W'(k)) begin
                sel_px  = src_px_i[k*PX_W +: PX_W];
                sel_rdy = src_rdy_i[k];
            end
        end
    end

    assign full       = count == (AW+1)'(DEPTH);
    assign pop        = sink_ack_i && sink_vld_o;
    // Results count only while a frame is active and still owed pixels.
    assign push       = core_rdy_i && state != IDLE && out_cnt != len && !clr_i;
    // When full, a concurrent pop frees the head slot, which is also the write slot.
    assign wr_en      = push && (!full || pop);
    assign sink_vld_o = count != '0;
    assign sink_px_o  = sink_vld_o ? mem[rd_ptr] : '0;
    assign busy_o     = state != IDLE;

    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= core_px_i;
    end

    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state        <= IDLE;
            sel          <= '0;
            len          <= '0;
            in_cnt       <= '0;
            out_cnt      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            core_px_o    <= '0;
            core_rdy_o   <= 1'b0;
            frame_done_o <= 1'b0;
            ovf_o        <= 1'b0;
        end else if (clr_i) begin
            state        <= IDLE;
            in_cnt       <= '0;
            out_cnt      <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            core_rdy_o   <= 1'b0;
            frame_done_o <= 1'b0;
            ovf_o        <= 1'b0;
        end else begin
            core_rdy_o   <= 1'b0;
            frame_done_o <= 1'b0;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop) count <= count + 1'b1;
            else if (pop && !wr_en) count <= count - 1'b1;
            if (push) out_cnt <= out_cnt + 1'b1;
            if (push && full && !pop) ovf_o <= 1'b1;
            case (state)
                IDLE: begin
                    if (start_i && frame_len_i != '0 && {1'b0, sel_i} < (SEL_W+1)'(N_SRC)) begin
                        state   <= RUN;
                        sel     <= sel_i;
                        len     <= frame_len_i;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                    end
                end
                RUN: begin
                    if (sel_rdy) begin
                        core_rdy_o <= 1'b1;
                        core_px_o  <= sel_px;
                        in_cnt     <= in_cnt + 1'b1;
                        if (in_cnt + 1'b1 == len) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (out_cnt == len && count == '0) begin
                        state        <= IDLE;
                        frame_done_o <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_px_stream_router.sv
// tb_px_stream_router: table vectors, directed corner sequences and random traffic
// checked cycle by cycle against a queue-based reference model.
module tb_px_stream_router;
    localparam int PX_W  = 24;
    localparam int N_SRC = 3;
    localparam int DEPTH = 8;
    localparam int CNT_W = 16;

    logic                  clk_i = 1'b0;
    logic                  nrst;
    logic                  start, clr, crdy, ack;
    logic [1:0]            sel;
    logic [CNT_W-1:0]      flen;
    logic [N_SRC*PX_W-1:0] spx;
    logic [N_SRC-1:0]      srdy;
    logic [PX_W-1:0]       cpx;
    logic [PX_W-1:0]       core_px_o, sink_px_o;
    logic                  core_rdy_o, sink_vld_o, busy_o, frame_done_o, ovf_o;

    int total = 0;
    int bad   = 0;

    // reference model state
    int              m_mode, m_sel, m_len, m_in, m_out;
    bit              m_ovf, e_rdy, e_done;
    logic [PX_W-1:0] e_px;
    logic [PX_W-1:0] q[$];

    typedef struct {
        logic             start;
        logic [1:0]       sel;
        logic [CNT_W-1:0] len;
        logic [2:0]       srdy;
        logic [PX_W-1:0]  px0, px1;
        logic             crdy;
        logic [PX_W-1:0]  cpx;
        logic             ack;
        logic             e_rdy;
        logic [PX_W-1:0]  e_px;
        logic             e_vld;
        logic [PX_W-1:0]  e_spx;
        logic             e_busy, e_done;
    } vec_t;

    vec_t tbl[15];

    px_stream_router #(.PX_W(PX_W), .N_SRC(N_SRC), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk_i(clk_i), .nreset_i(nrst), .start_i(start), .clr_i(clr), .sel_i(sel),
        .frame_len_i(flen), .src_px_i(spx), .src_rdy_i(srdy), .core_px_o(core_px_o),
        .core_rdy_o(core_rdy_o), .core_px_i(cpx), .core_rdy_i(crdy), .sink_px_o(sink_px_o),
        .sink_vld_o(sink_vld_o), .sink_ack_i(ack), .busy_o(busy_o),
        .frame_done_o(frame_done_o), .ovf_o(ovf_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    function automatic vec_t mk(int st, int sl, int ln, int sr, int p0, int p1, int cr, int cp,
                                int ak, int er, int ep, int ev, int es, int eb, int ed);
        vec_t v;
        v.start = st[0]; v.sel = sl[1:0]; v.len = ln[CNT_W-1:0]; v.srdy = sr[2:0];
        v.px0 = p0[PX_W-1:0]; v.px1 = p1[PX_W-1:0]; v.crdy = cr[0]; v.cpx = cp[PX_W-1:0];
        v.ack = ak[0]; v.e_rdy = er[0]; v.e_px = ep[PX_W-1:0]; v.e_vld = ev[0];
        v.e_spx = es[PX_W-1:0]; v.e_busy = eb[0]; v.e_done = ed[0];
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_sel = 0; m_len = 0; m_in = 0; m_out = 0;
        m_ovf = 0; e_rdy = 0; e_done = 0; e_px = '0;
        q.delete();
    endtask

    // Next-cycle expectations from the current inputs and the model's frame bookkeeping.
    task automatic model_step();
        int old_mode = m_mode;
        bit pop_ok, push_ok;
        e_rdy  = 0;
        e_done = 0;
        if (clr) begin
            m_mode = 0; m_in = 0; m_out = 0; m_ovf = 0;
            q.delete();
            return;
        end
        pop_ok  = ack && q.size() != 0;
        push_ok = crdy && old_mode != 0 && m_out < m_len;
        if (old_mode == 0 && start && flen != 0 && int'(sel) < N_SRC) begin
            m_mode = 1; m_sel = int'(sel); m_len = int'(flen); m_in = 0; m_out = 0;
        end
        if (old_mode == 1 && srdy[m_sel]) begin
            e_rdy = 1;
            e_px  = spx[m_sel*PX_W +: PX_W];
            m_in++;
            if (m_in == m_len) m_mode = 2;
        end
        if (old_mode == 2 && m_out == m_len && q.size() == 0) begin
            m_mode = 0;
            e_done = 1;
        end
        if (pop_ok) void'(q.pop_front());
        if (push_ok) begin
            m_out++;
            if (q.size() < DEPTH) q.push_back(cpx);
            else m_ovf = 1;
        end
    endtask

    task automatic check_all();
        logic [PX_W-1:0] head;
        head = q.size() != 0 ? q[0] : '0;
        chk("core_rdy", 32'(core_rdy_o), 32'(e_rdy));
        chk("core_px", 32'(core_px_o), 32'(e_px));
        chk("sink_vld", 32'(sink_vld_o), 32'(q.size() != 0));
        chk("sink_px", 32'(sink_px_o), 32'(head));
        chk("busy", 32'(busy_o), 32'(m_mode != 0));
        chk("frame_done", 32'(frame_done_o), 32'(e_done));
        chk("ovf", 32'(ovf_o), 32'(m_ovf));
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk_i);
        #1;
        check_all();
    endtask

    task automatic set_idle();
        start = 0; clr = 0; sel = '0; flen = '0; srdy = '0; spx = '0;
        crdy = 0; cpx = '0; ack = 0;
    endtask

    task automatic begin_frame(input int s, input int l);
        set_idle();
        start = 1; sel = 2'(s); flen = CNT_W'(l);
        cyc();
        start = 0;
    endtask

    task automatic drain(input int base, input int n_exp);
        int n = 0;
        bit seen = 0;
        set_idle();
        ack = 1;
        for (int c = 0; c < 24 && !seen; c++) begin
            if (sink_vld_o) begin
                chk("drain_order", 32'(sink_px_o), 32'(base + n));
                n++;
            end
            cyc();
            seen = frame_done_o;
        end
        chk("drain_count", 32'(n), 32'(n_exp));
        chk("drain_done", 32'(seen), 32'(1));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_core_px"}, 32'(core_px_o), 32'(0));
        chk({tag, "_core_rdy"}, 32'(core_rdy_o), 32'(0));
        chk({tag, "_sink_px"}, 32'(sink_px_o), 32'(0));
        chk({tag, "_sink_vld"}, 32'(sink_vld_o), 32'(0));
        chk({tag, "_busy"}, 32'(busy_o), 32'(0));
        chk({tag, "_done"}, 32'(frame_done_o), 32'(0));
        chk({tag, "_ovf"}, 32'(ovf_o), 32'(0));
    endtask

    initial begin
        int done_cnt = 0;
        int bias;
        tbl[0]  = mk(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        tbl[1]  = mk(0, 0, 0, 3, 'hA01, 'hB01, 0, 0, 0, 1, 'hB01, 0, 0, 1, 0);
        tbl[2]  = mk(0, 0, 0, 1, 'hA02, 0, 0, 0, 0, 0, 'hB01, 0, 0, 1, 0);
        tbl[3]  = mk(0, 0, 0, 2, 0, 'hB02, 0, 0, 0, 1, 'hB02, 0, 0, 1, 0);
        tbl[4]  = mk(0, 0, 0, 2, 0, 'hB03, 1, 'hA1, 1, 1, 'hB03, 1, 'hA1, 1, 0);
        tbl[5]  = mk(0, 0, 0, 2, 0, 'hB04, 1, 'hA2, 1, 1, 'hB04, 1, 'hA2, 1, 0);
        tbl[6]  = mk(0, 0, 0, 3, 'hA05, 'hB05, 0, 0, 1, 0, 'hB04, 0, 0, 1, 0);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 'hA3, 1, 0, 'hB04, 1, 'hA3, 1, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, 'hA4, 1, 0, 'hB04, 1, 'hA4, 1, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'hB04, 0, 0, 1, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hB04, 0, 0, 0, 1);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hB04, 0, 0, 0, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 'hB04, 0, 0, 0, 0);
        tbl[13] = mk(1, 3, 5, 0, 0, 0, 0, 0, 0, 0, 'hB04, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0, 0, 0, 0, 1, 'hEE, 0, 0, 'hB04, 0, 0, 0, 0);

        set_idle();
        model_reset();
        nrst = 1;
        #1 nrst = 0;
        #2 chk_zero("reset");
        @(posedge clk_i);
        @(posedge clk_i);
        #1 nrst = 1;

        // frame of 4 on source 1 with source 0 chatter, then the core results drain
        for (int i = 0; i < 15; i++) begin
            start = tbl[i].start; sel = tbl[i].sel; flen = tbl[i].len; srdy = tbl[i].srdy;
            spx = {24'h0, tbl[i].px1, tbl[i].px0};
            crdy = tbl[i].crdy; cpx = tbl[i].cpx; ack = tbl[i].ack; clr = 0;
            cyc();
            chk($sformatf("tbl%0d_rdy", i), 32'(core_rdy_o), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_px", i), 32'(core_px_o), 32'(tbl[i].e_px));
            chk($sformatf("tbl%0d_vld", i), 32'(sink_vld_o), 32'(tbl[i].e_vld));
            chk($sformatf("tbl%0d_spx", i), 32'(sink_px_o), 32'(tbl[i].e_spx));
            chk($sformatf("tbl%0d_busy", i), 32'(busy_o), 32'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_done", i), 32'(frame_done_o), 32'(tbl[i].e_done));
        end

        // overflow: ten results into an eight-deep FIFO with the sink stalled
        begin_frame(0, 10);
        for (int i = 0; i < 10; i++) begin
            srdy = 3'b001; spx = {48'h0, 24'(32'h500 + i)};
            crdy = 1; cpx = 24'(32'h100 + i); ack = 0;
            cyc();
        end
        chk("ovf_set", 32'(ovf_o), 32'(1));
        chk("ovf_head", 32'(sink_px_o), 32'h100);
        drain(32'h100, 8);
        chk("ovf_sticky", 32'(ovf_o), 32'(1));
        set_idle(); clr = 1; cyc(); clr = 0;
        chk("ovf_clr", 32'(ovf_o), 32'(0));

        // full FIFO with a same-cycle push and pop
        begin_frame(2, 9);
        for (int i = 0; i < 9; i++) begin
            srdy = 3'b100; spx = {24'(32'h600 + i), 48'h0};
            crdy = 1; cpx = 24'(32'h200 + i); ack = (i == 8);
            cyc();
        end
        chk("full_pp_ovf", 32'(ovf_o), 32'(0));
        chk("full_pp_head", 32'(sink_px_o), 32'h201);
        drain(32'h201, 8);

        // abort mid-frame, then a complete frame
        begin_frame(2, 5);
        for (int i = 0; i < 2; i++) begin
            srdy = 3'b100; spx = {24'(32'h700 + i), 48'h0}; crdy = 1; cpx = 24'(32'h250 + i);
            cyc();
        end
        set_idle(); clr = 1; cyc(); clr = 0;
        chk("clr_busy", 32'(busy_o), 32'(0));
        chk("clr_vld", 32'(sink_vld_o), 32'(0));
        chk("clr_rdy", 32'(core_rdy_o), 32'(0));
        chk("clr_done", 32'(frame_done_o), 32'(0));
        cyc();
        chk("clr_done_after", 32'(frame_done_o), 32'(0));
        begin_frame(2, 5);
        for (int i = 0; i < 5; i++) begin
            srdy = 3'b100; spx = {24'(32'h800 + i), 48'h0};
            crdy = 1; cpx = 24'(32'h300 + i); ack = 1;
            cyc();
        end
        drain(32'h304, 1);

        // zero-length start, then reset asserted mid-drain
        begin_frame(0, 0);
        chk("len0_busy", 32'(busy_o), 32'(0));
        begin_frame(1, 2);
        for (int i = 0; i < 2; i++) begin
            srdy = 3'b010; spx = {24'h0, 24'(32'h900 + i), 24'h0};
            cyc();
        end
        set_idle(); crdy = 1; cpx = 24'h400; cyc();
        chk("pre_rst_busy", 32'(busy_o), 32'(1));
        nrst = 0;
        #1 chk_zero("rst_async");
        model_reset();
        @(posedge clk_i);
        #1 nrst = 1;
        srdy = 3'b111; spx = {3{24'h123456}}; crdy = 1;
        cyc();
        chk("post_rst_rdy", 32'(core_rdy_o), 32'(0));
        chk("post_rst_busy", 32'(busy_o), 32'(0));

        // random traffic, sink throughput varying by phase
        bias = 3;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) bias = int'($urandom_range(0, 4));
            start = $urandom_range(0, 7) == 0;
            sel   = 2'($urandom_range(0, 3));
            flen  = CNT_W'($urandom_range(0, 12));
            srdy  = 3'($urandom);
            spx   = {24'($urandom), 24'($urandom), 24'($urandom)};
            crdy  = $urandom_range(0, 2) != 0;
            cpx   = 24'($urandom);
            ack   = int'($urandom_range(0, 3)) < bias;
            clr   = $urandom_range(0, 199) == 0;
            cyc();
            if (frame_done_o) done_cnt++;
        end
        chk("rand_frames", 32'(done_cnt > 0), 32'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
